// File: rtl/knight_pkg.sv
// Shared constants and types for the knight-tour command scheduler.
// Holds cmd_proc opcodes, headings, response bytes, FSM states and the move-leg bundle.
package knight_pkg;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_MOVE_FF = 4'h3;

    localparam logic [7:0] HD_N = 8'h00;
    localparam logic [7:0] HD_W = 8'h3F;
    localparam logic [7:0] HD_S = 8'h7F;
    localparam logic [7:0] HD_E = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        VWAIT,
        HORZ,
        HWAIT
    } state_t;

    typedef struct packed {
        logic [7:0] heading;
        logic [3:0] squares;
    } move_leg_t;

    function automatic move_leg_t mk_leg(
        input logic [7:0] hd,
        input logic [3:0] sq
    );
        move_leg_t l;
        l.heading = hd;
        l.squares = sq;
        return l;
    endfunction

    function automatic logic [15:0] leg_cmd(
        input logic [3:0] op,
        input move_leg_t  leg
    );
        return {op, leg.heading, leg.squares};
    endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Combinational decode of a one-hot knight move into its vertical and horizontal legs.
// Ports: move[7:0] in; vert, horz (move_leg_t) out; valid out (low when move==0).
module knight_move_decode
    import knight_pkg::*;
(
    input  logic [7:0] move,
    output move_leg_t  vert,
    output move_leg_t  horz,
    output logic       valid
);

    // Lowest set bit wins when the solver hands us more than one bit.
    always_comb begin
        vert  = '0;
        horz  = '0;
        valid = 1'b1;
        priority casez (move)
            8'b???????1: begin
                vert = mk_leg(HD_N, 4'd2);
                horz = mk_leg(HD_W, 4'd1);
            end
            8'b??????10: begin
                vert = mk_leg(HD_N, 4'd2);
                horz = mk_leg(HD_E, 4'd1);
            end
            8'b?????100: begin
                vert = mk_leg(HD_N, 4'd1);
                horz = mk_leg(HD_W, 4'd2);
            end
            8'b????1000: begin
                vert = mk_leg(HD_S, 4'd1);
                horz = mk_leg(HD_W, 4'd2);
            end
            8'b???10000: begin
                vert = mk_leg(HD_S, 4'd2);
                horz = mk_leg(HD_W, 4'd1);
            end
            8'b??100000: begin
                vert = mk_leg(HD_S, 4'd2);
                horz = mk_leg(HD_E, 4'd1);
            end
            8'b?1000000: begin
                vert = mk_leg(HD_S, 4'd1);
                horz = mk_leg(HD_E, 4'd2);
            end
            8'b10000000: begin
                vert = mk_leg(HD_N, 4'd1);
                horz = mk_leg(HD_E, 4'd2);
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/tour_cmd_sched.sv
// Shares cmd_proc's command input between the UART path and the tour solver,
// expanding each stored knight move into a vertical then a horizontal command.
// Ports: clk, rst (async, active high); uart_cmd/uart_cmd_rdy in, clr_uart_cmd_rdy out;
// start_tour, move in, mv_indx out; cmd/cmd_rdy out, clr_cmd_rdy/send_resp in; resp out.
module tour_cmd_sched
    import knight_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] uart_cmd,
    input  logic        uart_cmd_rdy,
    output logic        clr_uart_cmd_rdy,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [4:0] idx_nxt;
    logic [15:0] cmd_q, cmd_d;
    logic       rdy_q, rdy_d;
    move_leg_t  hleg_q, hleg_d;

    move_leg_t  dec_v, dec_h;
    logic       dec_ok;
    logic       is_last;
    logic       begin_tour;
    logic       advance;
    logic       load;
    logic       pass;

    knight_move_decode u_dec (
        .move  (move),
        .vert  (dec_v),
        .horz  (dec_h),
        .valid (dec_ok)
    );

    assign is_last = (idx_q == LAST);
    assign idx_nxt = is_last ? idx_q : idx_q + 5'd1;

    assign begin_tour = (state_q == IDLE) && start_tour;

    // Step to the next move after a finished horizontal leg or a skipped move.
    // A skipped move sits in VERT with no command pending.
    assign advance = !is_last
                   && (((state_q == HWAIT) && send_resp)
                    || ((state_q == VERT) && !rdy_q));

    assign load = begin_tour || advance;

    // mv_indx looks ahead to the index being loaded so the solver memory
    // already presents that move when the command register captures it.
    assign mv_indx = begin_tour ? 5'd0
                   : advance    ? idx_nxt
                   :              idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cmd_q   <= '0;
            rdy_q   <= 1'b0;
            hleg_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            rdy_q   <= rdy_d;
            hleg_q  <= hleg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        rdy_d   = rdy_q;
        hleg_d  = hleg_q;
        resp    = RESP_BUSY;
        unique case (state_q)
            IDLE: begin
                resp = RESP_DONE;
            end
            VERT: begin
                if (!rdy_q) begin
                    if (is_last) state_d = IDLE;
                end else if (clr_cmd_rdy) begin
                    state_d = VWAIT;
                    rdy_d   = 1'b0;
                end
            end
            VWAIT: begin
                if (send_resp) begin
                    state_d = HORZ;
                    cmd_d   = leg_cmd(OP_MOVE_FF, hleg_q);
                    rdy_d   = 1'b1;
                end
            end
            HORZ: begin
                if (clr_cmd_rdy) begin
                    state_d = HWAIT;
                    rdy_d   = 1'b0;
                end
            end
            HWAIT: begin
                if (send_resp && is_last) begin
                    state_d = IDLE;
                    resp    = RESP_DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = VERT;
            idx_d   = mv_indx;
            cmd_d   = dec_ok ? leg_cmd(OP_MOVE, dec_v) : 16'h0000;
            rdy_d   = dec_ok;
            hleg_d  = dec_h;
        end
    end

    // A starting tour takes priority, so the UART command stays pending.
    assign pass = (state_q == IDLE) && !start_tour && !rst;

    assign cmd              = (state_q == IDLE) ? uart_cmd : cmd_q;
    assign cmd_rdy          = (state_q == IDLE) ? (uart_cmd_rdy && pass) : rdy_q;
    assign clr_uart_cmd_rdy = pass && clr_cmd_rdy;

endmodule

// File: tb/tb_tour_cmd_sched.sv
// Randomized bench for tour_cmd_sched: plays solver memory, UART source and cmd_proc,
// and checks every leg against a move-list model of the tour.
module tb_tour_cmd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] uart_cmd;
    logic        uart_cmd_rdy;
    logic        clr_uart_cmd_rdy;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    logic [7:0]  mem [32];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign move = mem[mv_indx];

    tour_cmd_sched #(.NUM_MOVES(24)) dut (
        .clk              (clk),
        .rst              (rst),
        .uart_cmd         (uart_cmd),
        .uart_cmd_rdy     (uart_cmd_rdy),
        .clr_uart_cmd_rdy (clr_uart_cmd_rdy),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    // Knight move table indexed by the lowest set bit.
    localparam logic [7:0] VH [8] = '{8'h00, 8'h00, 8'h00, 8'h7F,
                                      8'h7F, 8'h7F, 8'h7F, 8'h00};
    localparam logic [3:0] VS [8] = '{4'd2, 4'd2, 4'd1, 4'd1,
                                      4'd2, 4'd2, 4'd1, 4'd1};
    localparam logic [7:0] HH [8] = '{8'h3F, 8'hBF, 8'h3F, 8'h3F,
                                      8'h3F, 8'hBF, 8'hBF, 8'hBF};
    localparam logic [3:0] HS [8] = '{4'd1, 4'd1, 4'd2, 4'd2,
                                      4'd1, 4'd1, 4'd2, 4'd2};

    typedef struct {
        logic [15:0] cmd;
        int          gap;
        int          idx;
        logic [7:0]  resp;
    } leg_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int low_bit(input logic [7:0] m);
        for (int b = 0; b < 8; b++)
            if (m[b]) return b;
        return -1;
    endfunction

    task automatic fill_mem(input bit one_hot_only);
        int r;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        for (int i = 0; i < 24; i++) begin
            r = one_hot_only ? 9 : $urandom_range(0, 9);
            if (r == 0)      mem[i] = 8'h00;
            else if (r < 3)  mem[i] = 8'($urandom);
            else             mem[i] = 8'(1 << $urandom_range(0, 7));
        end
    endtask

    // Expected legs: each non-zero move gives two commands; each skipped move
    // delays the next command (or the return to IDLE) by one cycle.
    task automatic run_tour(input int uart_leg, input bit uart_start,
                            input bit lit, input logic [15:0] lit0,
                            input logic [15:0] lit1);
        leg_t q[$];
        leg_t e;
        int gap, b, n, w, ul;
        logic [15:0] seen0, seen1;
        gap = 1;
        for (int i = 0; i < 24; i++) begin
            if (mem[i] == 8'h00) begin
                gap++;
            end else begin
                b = low_bit(mem[i]);
                e.cmd = {4'h2, VH[b], VS[b]};
                e.gap = gap; e.idx = i; e.resp = 8'h5A;
                q.push_back(e);
                e.cmd = {4'h3, HH[b], HS[b]};
                e.gap = 1; e.idx = i;
                e.resp = (i == 23) ? 8'hA5 : 8'h5A;
                q.push_back(e);
                gap = 1;
            end
        end
        ul = (uart_leg >= q.size()) ? q.size() - 1 : uart_leg;
        seen0 = '0;
        seen1 = '0;
        @(negedge clk);
        if (uart_start) begin
            uart_cmd     = 16'($urandom);
            uart_cmd_rdy = 1'b1;
        end
        start_tour = 1'b1;
        for (int k = 0; k < q.size(); k++) begin
            n = 0;
            do begin
                @(negedge clk);
                start_tour = 1'b0;
                send_resp  = 1'b0;
                n++;
            end while (!cmd_rdy && n < 40);
            check("leg_latency", n, q[k].gap);
            check("leg_cmd", cmd, q[k].cmd);
            check("leg_index", mv_indx, q[k].idx);
            if (k == 0) seen0 = cmd;
            if (k == 1) seen1 = cmd;
            clr_cmd_rdy = 1'b1;
            send_resp   = ($urandom_range(0, 3) == 0);
            if (uart_cmd_rdy) begin
                #1;
                check("uart_held", clr_uart_cmd_rdy, 0);
            end
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            send_resp   = 1'b0;
            check("wait_no_rdy", cmd_rdy, 0);
            if (k == ul && !uart_cmd_rdy) begin
                uart_cmd     = 16'($urandom);
                uart_cmd_rdy = 1'b1;
            end
            w = $urandom_range(0, 3);
            for (int j = 0; j < w; j++) begin
                start_tour = 1'($urandom_range(0, 1));
                @(negedge clk);
                start_tour = 1'b0;
                check("wait_no_rdy", cmd_rdy, 0);
            end
            send_resp = 1'b1;
            #1;
            check("resp", resp, q[k].resp);
        end
        for (int j = 1; j <= gap; j++) begin
            @(negedge clk);
            start_tour = 1'b0;
            send_resp  = 1'b0;
            if (j < gap) check("tail_no_rdy", cmd_rdy, 0);
        end
        check("end_index", mv_indx, 23);
        check("end_resp", resp, 8'hA5);
        if (uart_cmd_rdy) begin
            check("uart_fwd_rdy", cmd_rdy, 1);
            check("uart_fwd_cmd", cmd, uart_cmd);
            clr_cmd_rdy = 1'b1;
            #1;
            check("uart_fwd_clr", clr_uart_cmd_rdy, 1);
            @(negedge clk);
            clr_cmd_rdy  = 1'b0;
            uart_cmd_rdy = 1'b0;
        end
        if (lit) begin
            check("lit_first_cmd", seen0, lit0);
            check("lit_second_cmd", seen1, lit1);
        end
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        uart_cmd     = '0;
        uart_cmd_rdy = 1'b0;
        start_tour   = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_mv_indx", mv_indx, 0);
        check("rst_resp", resp, 8'hA5);
        check("rst_clr_uart", clr_uart_cmd_rdy, 0);
        rst = 1'b0;

        // IDLE pass-through
        @(negedge clk);
        uart_cmd     = 16'h2001;
        uart_cmd_rdy = 1'b1;
        #1;
        check("pass_cmd", cmd, 16'h2001);
        check("pass_rdy", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        #1;
        check("pass_clr", clr_uart_cmd_rdy, 1);
        @(negedge clk);
        clr_cmd_rdy  = 1'b0;
        uart_cmd_rdy = 1'b0;
        #1;
        check("pass_rdy_low", cmd_rdy, 0);
        check("pass_clr_low", clr_uart_cmd_rdy, 0);

        // Tour with a skip at index 5 and UART arriving mid-tour
        fill_mem(1'b0);
        mem[0] = 8'h01;
        mem[5] = 8'h00;
        run_tour(3, 1'b0, 1'b1, 16'h2002, 16'h33F1);

        // Multi-bit move, skipped final move, UART racing start_tour
        fill_mem(1'b0);
        mem[0]  = 8'h41;
        mem[23] = 8'h00;
        run_tour(99, 1'b1, 1'b1, 16'h2002, 16'h33F1);

        // Fully random tours
        for (int t = 0; t < 3; t++) begin
            fill_mem(1'b0);
            run_tour($urandom_range(0, 10), 1'b0, 1'b0, '0, '0);
        end

        // Every move skipped
        for (int i = 0; i < 24; i++) mem[i] = 8'h00;
        run_tour(99, 1'b1, 1'b0, '0, '0);

        // Reset while a horizontal leg is pending
        fill_mem(1'b1);
        mem[0] = 8'h00;
        mem[1] = 8'h00;
        mem[2] = 8'h80;
        @(negedge clk);
        start_tour = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start_tour = 1'b0;
            n++;
        end while (!cmd_rdy && n < 40);
        check("rt_latency", n, 3);
        check("rt_vert_cmd", cmd, 16'h2001);
        check("rt_index", mv_indx, 2);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b1;
        #1;
        check("rt_resp", resp, 8'h5A);
        @(negedge clk);
        send_resp = 1'b0;
        check("rt_horz_rdy", cmd_rdy, 1);
        check("rt_horz_cmd", cmd, 16'h3BF2);
        uart_cmd     = 16'h2BC3;
        uart_cmd_rdy = 1'b1;
        clr_cmd_rdy  = 1'b1;
        rst          = 1'b1;
        #1;
        check("rt_cmd_rdy", cmd_rdy, 0);
        check("rt_mv_indx", mv_indx, 0);
        check("rt_clr_uart", clr_uart_cmd_rdy, 0);
        check("rt_resp_done", resp, 8'hA5);
        @(negedge clk);
        rst         = 1'b0;
        clr_cmd_rdy = 1'b0;
        #1;
        check("rt_pass_rdy", cmd_rdy, 1);
        check("rt_pass_cmd", cmd, 16'h2BC3);
        clr_cmd_rdy = 1'b1;
        #1;
        check("rt_pass_clr", clr_uart_cmd_rdy, 1);
        @(negedge clk);
        clr_cmd_rdy  = 1'b0;
        uart_cmd_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
